// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the cache-to-memory arbiter slice.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IC_READ,
        ST_DC_READ,
        ST_DC_WRITE,
        ST_RELEASE
    } t_arb_state;

    localparam int unsigned BLOCK_BEATS = 16;

    // One extra bit so a full write burst (count == beats) is representable.
    function automatic int unsigned beat_cnt_width(input int unsigned beats);
        return $clog2(beats) + 1;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_beat_counter.sv
// Burst beat counter: increments on inc_i, returns to zero only on clear_i.
module beat_counter
    import cache_pkg::*;
#(
    parameter int unsigned BEATS = BLOCK_BEATS
) (
    input  logic clk,
    input  logic arstn,
    input  logic inc_i,
    input  logic clear_i,
    output logic last_o,
    output logic full_o
);

    localparam int unsigned W = beat_cnt_width(BEATS);
    localparam logic [W-1:0] LAST = W'(BEATS - 1);
    localparam logic [W-1:0] FULL = W'(BEATS);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == LAST);
    assign full_o = (count_q == FULL);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Grants the shared memory port to the icache or dcache and generates the
// per-requester beat valid, last and done pulses.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BLOCK_BEATS = cache_pkg::BLOCK_BEATS
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_ic_start_read,
    input  logic [ADDR_WIDTH-1:0] i_ic_addr,
    input  logic                  i_dc_start_read,
    input  logic                  i_dc_start_write,
    input  logic [ADDR_WIDTH-1:0] i_dc_addr,
    input  logic [DATA_WIDTH-1:0] i_dc_w_data,
    output logic                  o_mem_start_read,
    output logic                  o_mem_start_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_w_data,
    input  logic                  i_mem_r_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_r_data,
    input  logic                  i_mem_w_ready,
    input  logic                  i_mem_b_valid,
    output logic                  o_ic_r_valid,
    output logic                  o_dc_r_valid,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic                  o_ic_r_last,
    output logic                  o_dc_r_last,
    output logic                  o_dc_w_next,
    output logic                  o_dc_b_done
);

    t_arb_state state_q, state_d;
    logic       last_dc_q, last_dc_d;
    logic       cnt_inc, cnt_clr, cnt_last, cnt_full;

    beat_counter #(
        .BEATS(BLOCK_BEATS)
    ) u_beat_counter (
        .clk    (clk),
        .arstn  (arstn),
        .inc_i  (cnt_inc),
        .clear_i(cnt_clr),
        .last_o (cnt_last),
        .full_o (cnt_full)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= ST_IDLE;
            last_dc_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_dc_q <= last_dc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_dc_d = last_dc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_dc_start_write) begin
                    state_d = ST_DC_WRITE;
                end else if (i_ic_start_read && (!i_dc_start_read || last_dc_q)) begin
                    state_d   = ST_IC_READ;
                    last_dc_d = 1'b0;
                end else if (i_dc_start_read) begin
                    state_d   = ST_DC_READ;
                    last_dc_d = 1'b1;
                end
            end
            ST_IC_READ, ST_DC_READ: begin
                if (i_mem_r_valid && cnt_last) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_DC_WRITE: begin
                if (cnt_full && i_mem_b_valid) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Beats outside a grant never reach the counter or the caches.
    always_comb begin
        o_mem_start_read  = 1'b0;
        o_mem_start_write = 1'b0;
        o_mem_addr        = '0;
        o_ic_r_valid      = 1'b0;
        o_dc_r_valid      = 1'b0;
        o_ic_r_last       = 1'b0;
        o_dc_r_last       = 1'b0;
        o_dc_w_next       = 1'b0;
        o_dc_b_done       = 1'b0;
        cnt_inc           = 1'b0;
        cnt_clr           = 1'b0;
        unique case (state_q)
            ST_IC_READ: begin
                o_mem_start_read = 1'b1;
                o_mem_addr       = i_ic_addr;
                o_ic_r_valid     = i_mem_r_valid;
                o_ic_r_last      = i_mem_r_valid && cnt_last;
                cnt_inc          = i_mem_r_valid;
                cnt_clr          = i_mem_r_valid && cnt_last;
            end
            ST_DC_READ: begin
                o_mem_start_read = 1'b1;
                o_mem_addr       = i_dc_addr;
                o_dc_r_valid     = i_mem_r_valid;
                o_dc_r_last      = i_mem_r_valid && cnt_last;
                cnt_inc          = i_mem_r_valid;
                cnt_clr          = i_mem_r_valid && cnt_last;
            end
            ST_DC_WRITE: begin
                o_mem_start_write = 1'b1;
                o_mem_addr        = i_dc_addr;
                o_dc_w_next       = i_mem_w_ready && !cnt_full;
                o_dc_b_done       = cnt_full && i_mem_b_valid;
                cnt_inc           = i_mem_w_ready && !cnt_full;
                cnt_clr           = cnt_full && i_mem_b_valid;
            end
            default: ;
        endcase
    end

    assign o_r_data     = i_mem_r_data;
    assign o_mem_w_data = i_dc_w_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed/randomized bench for cache_mem_arbiter against a transaction-level model.
module tb_cache_mem_arbiter;
    import cache_pkg::*;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int BB = 16;

    logic          clk = 1'b0;
    logic          arstn;
    logic          i_ic_start_read, i_dc_start_read, i_dc_start_write;
    logic [AW-1:0] i_ic_addr, i_dc_addr;
    logic [DW-1:0] i_dc_w_data, i_mem_r_data;
    logic          i_mem_r_valid, i_mem_w_ready, i_mem_b_valid;
    logic          o_mem_start_read, o_mem_start_write;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_w_data, o_r_data;
    logic          o_ic_r_valid, o_dc_r_valid, o_ic_r_last, o_dc_r_last;
    logic          o_dc_w_next, o_dc_b_done;

    cache_mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BLOCK_BEATS(BB)
    ) dut (
        .clk              (clk),
        .arstn            (arstn),
        .i_ic_start_read  (i_ic_start_read),
        .i_ic_addr        (i_ic_addr),
        .i_dc_start_read  (i_dc_start_read),
        .i_dc_start_write (i_dc_start_write),
        .i_dc_addr        (i_dc_addr),
        .i_dc_w_data      (i_dc_w_data),
        .o_mem_start_read (o_mem_start_read),
        .o_mem_start_write(o_mem_start_write),
        .o_mem_addr       (o_mem_addr),
        .o_mem_w_data     (o_mem_w_data),
        .i_mem_r_valid    (i_mem_r_valid),
        .i_mem_r_data     (i_mem_r_data),
        .i_mem_w_ready    (i_mem_w_ready),
        .i_mem_b_valid    (i_mem_b_valid),
        .o_ic_r_valid     (o_ic_r_valid),
        .o_dc_r_valid     (o_dc_r_valid),
        .o_r_data         (o_r_data),
        .o_ic_r_last      (o_ic_r_last),
        .o_dc_r_last      (o_dc_r_last),
        .o_dc_w_next      (o_dc_w_next),
        .o_dc_b_done      (o_dc_b_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model of pending requests and tie-break history.
    bit pend_ic, pend_dr, pend_dw;
    bit last_dc_m;
    int ic_pulses, ic_lasts, b_dones;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_rd"}, o_mem_start_read, 1'b0);
        chk1({tag, "_wr"}, o_mem_start_write, 1'b0);
        chk1({tag, "_icv"}, o_ic_r_valid, 1'b0);
        chk1({tag, "_dcv"}, o_dc_r_valid, 1'b0);
        chk1({tag, "_icl"}, o_ic_r_last, 1'b0);
        chk1({tag, "_dcl"}, o_dc_r_last, 1'b0);
        chk1({tag, "_wn"}, o_dc_w_next, 1'b0);
        chk1({tag, "_bd"}, o_dc_b_done, 1'b0);
    endtask

    task automatic rd_burst(input bit is_dc, input int gap, input int raise_w_at);
        logic [AW-1:0] ea;
        int g;
        ea = is_dc ? i_dc_addr : i_ic_addr;
        for (int b = 1; b <= BB; b++) begin
            g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
            for (int k = 0; k < g; k++) begin
                i_mem_r_valid = 1'b0;
                smp();
                chk1("rd_cmd_gap", o_mem_start_read, 1'b1);
                chk1("rd_icv_gap", o_ic_r_valid, 1'b0);
                chk1("rd_dcv_gap", o_dc_r_valid, 1'b0);
                nxt();
            end
            i_mem_r_valid = 1'b1;
            i_mem_r_data  = DW'($urandom);
            if (b == raise_w_at) begin
                i_dc_start_write = 1'b1;
                pend_dw          = 1'b1;
            end
            smp();
            chk1("rd_cmd", o_mem_start_read, 1'b1);
            chk1("rd_wr_low", o_mem_start_write, 1'b0);
            chk64("rd_addr", o_mem_addr, ea);
            chk1("rd_icv", o_ic_r_valid, !is_dc);
            chk1("rd_dcv", o_dc_r_valid, is_dc);
            chk64("rd_data", 64'(o_r_data), 64'(i_mem_r_data));
            chk1("rd_icl", o_ic_r_last, !is_dc && (b == BB));
            chk1("rd_dcl", o_dc_r_last, is_dc && (b == BB));
            if (o_ic_r_valid) ic_pulses++;
            if (o_ic_r_last) ic_lasts++;
            nxt();
            i_mem_r_valid = 1'b0;
        end
    endtask

    task automatic wr_burst(input int bdelay);
        int g;
        for (int b = 1; b <= BB; b++) begin
            g = int'($urandom_range(2, 0));
            for (int k = 0; k < g; k++) begin
                i_mem_w_ready = 1'b0;
                i_mem_b_valid = 1'($urandom_range(1, 0));
                smp();
                chk1("wr_cmd_gap", o_mem_start_write, 1'b1);
                chk1("wr_next_gap", o_dc_w_next, 1'b0);
                chk1("wr_early_b", o_dc_b_done, 1'b0);
                nxt();
            end
            i_mem_b_valid = 1'b0;
            i_mem_w_ready = 1'b1;
            i_dc_w_data   = DW'($urandom);
            smp();
            chk1("wr_cmd", o_mem_start_write, 1'b1);
            chk1("wr_rd_low", o_mem_start_read, 1'b0);
            chk64("wr_addr", o_mem_addr, i_dc_addr);
            chk1("wr_next", o_dc_w_next, 1'b1);
            chk64("wr_data", 64'(o_mem_w_data), 64'(i_dc_w_data));
            chk1("wr_bdone_beat", o_dc_b_done, 1'b0);
            nxt();
            i_mem_w_ready = 1'b0;
        end
        for (int k = 0; k < bdelay; k++) begin
            smp();
            chk1("wr_wait_cmd", o_mem_start_write, 1'b1);
            chk1("wr_wait_bdone", o_dc_b_done, 1'b0);
            nxt();
        end
        i_mem_b_valid = 1'b1;
        smp();
        chk1("wr_cmd_done", o_mem_start_write, 1'b1);
        chk1("wr_bdone", o_dc_b_done, 1'b1);
        if (o_dc_b_done) b_dones++;
        nxt();
        i_mem_b_valid = 1'b0;
    endtask

    // Serve every pending request in model order; entered in an IDLE cycle.
    task automatic run_pending(input int gap, input int raise_w_at, input int bdelay);
        int  raise;
        bit  dc;
        raise = raise_w_at;
        while (pend_ic || pend_dr || pend_dw) begin
            smp();
            chk_quiet("idle");
            nxt();
            if (pend_dw) begin
                wr_burst(bdelay);
                i_dc_start_write = 1'b0;
                pend_dw          = 1'b0;
            end else begin
                dc = (pend_ic && pend_dr) ? !last_dc_m : pend_dr;
                rd_burst(dc, gap, raise);
                raise     = 0;
                last_dc_m = dc;
                if (dc) begin
                    i_dc_start_read = 1'b0;
                    pend_dr         = 1'b0;
                end else begin
                    i_ic_start_read = 1'b0;
                    pend_ic         = 1'b0;
                end
            end
            // Stray beat during release must not be delivered or counted.
            i_mem_r_valid = 1'b1;
            smp();
            chk_quiet("release");
            nxt();
            i_mem_r_valid = 1'b0;
        end
        chk1("back_to_idle", dut.state_q === ST_IDLE, 1'b1);
    endtask

    task automatic req(input bit ic, input bit dr, input bit dw);
        i_ic_addr = {$urandom, $urandom};
        i_dc_addr = {$urandom, $urandom};
        if (ic) begin i_ic_start_read  = 1'b1; pend_ic = 1'b1; end
        if (dr) begin i_dc_start_read  = 1'b1; pend_dr = 1'b1; end
        if (dw) begin i_dc_start_write = 1'b1; pend_dw = 1'b1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arstn = 1'b0;
        {i_ic_start_read, i_dc_start_read, i_dc_start_write} = '0;
        {i_mem_r_valid, i_mem_w_ready, i_mem_b_valid} = '0;
        i_ic_addr = '0; i_dc_addr = '0; i_dc_w_data = '0; i_mem_r_data = '0;
        last_dc_m = 1'b1;
        {pend_ic, pend_dr, pend_dw} = '0;
        ic_pulses = 0; ic_lasts = 0; b_dones = 0;
        repeat (3) nxt();
        smp();
        chk_quiet("reset");
        chk64("reset_addr", o_mem_addr, 64'd0);
        chk1("reset_state", dut.state_q === ST_IDLE, 1'b1);
        nxt();
        arstn = 1'b1;
        nxt();

        // Tie after reset: icache first, then dcache.
        req(1, 1, 0);
        run_pending(-1, 0, 0);

        // Lone icache read, back-to-back beats.
        ic_pulses = 0; ic_lasts = 0;
        req(1, 0, 0);
        run_pending(0, 0, 0);
        chk64("ic_pulse_count", 64'(ic_pulses), 64'(BB));
        chk64("ic_last_count", 64'(ic_lasts), 64'd1);

        // Tie again after an icache grant: dcache first.
        req(1, 1, 0);
        run_pending(-1, 0, 0);

        // dcache write raised mid icache burst, b_valid 3 cycles after last beat.
        b_dones = 0;
        req(1, 0, 0);
        run_pending(-1, 5, 3);
        chk64("b_done_count", 64'(b_dones), 64'd1);

        // 2-cycle gaps between beats.
        req(1, 0, 0);
        run_pending(2, 0, 0);

        // Spurious beats in IDLE, then a clean icache read.
        for (int k = 0; k < 3; k++) begin
            i_mem_r_valid = 1'b1;
            smp();
            chk_quiet("spurious");
            nxt();
        end
        i_mem_r_valid = 1'b0;
        req(1, 0, 0);
        run_pending(0, 0, 0);

        // Simultaneous dcache read and write: write first.
        req(0, 1, 1);
        run_pending(-1, 0, 1);

        // Reset at beat 7 of a dcache read.
        req(0, 1, 0);
        nxt();
        for (int b = 1; b <= 6; b++) begin
            i_mem_r_valid = 1'b1;
            smp();
            chk1("pre_reset_dcv", o_dc_r_valid, 1'b1);
            nxt();
        end
        i_mem_r_data = '0;
        i_dc_w_data  = '0;
        arstn        = 1'b0;
        smp();
        chk_quiet("mid_reset");
        chk64("mid_reset_addr", o_mem_addr, 64'd0);
        chk64("mid_reset_rdata", 64'(o_r_data), 64'd0);
        chk1("mid_reset_state", dut.state_q === ST_IDLE, 1'b1);
        nxt();
        i_mem_r_valid = 1'b0;
        arstn         = 1'b1;
        last_dc_m     = 1'b1;
        run_pending(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
